// File: rtl/acl_sample_scheduler.sv
// Accelerometer read sequencer: periodic SPI read requests, x/y/z capture,
// block averaging of 2^AVG_LOG2 samples, sticky timeout/overrun flags.
module acl_sample_scheduler #(
  parameter int SAMPLE_DIV     = 12000000,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int AVG_LOG2       = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       CLR_ERR,
  output logic       SPI_START,
  input  logic       SPI_DONE,
  input  logic [9:0] X_IN,
  input  logic [9:0] Y_IN,
  input  logic [9:0] Z_IN,
  output logic [9:0] X_AVG,
  output logic [9:0] Y_AVG,
  output logic [9:0] Z_AVG,
  output logic       AVG_VALID,
  output logic       BUSY,
  output logic       ERR_TIMEOUT,
  output logic       ERR_OVERRUN
);
  localparam int PW = $clog2(SAMPLE_DIV);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int SW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int AW = 10 + AVG_LOG2;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, ACCUM, EMIT} state_t;
  state_t state, state_nxt;

  logic [PW-1:0]    per_cnt;
  logic [TW-1:0]    to_cnt;
  logic [SW-1:0]    smp_cnt;
  logic             tick, to_hit, last_smp;
  logic [2:0][9:0]  din;
  logic signed [9:0]    cap [3];
  logic signed [AW-1:0] acc [3];
  logic [9:0]           avg [3];

  assign din      = {Z_IN, Y_IN, X_IN};
  assign tick     = EN && (per_cnt == PW'(SAMPLE_DIV - 1));
  // DONE arriving in the limit cycle takes priority over the timeout
  assign to_hit   = (state == WAIT) && (to_cnt == TW'(TIMEOUT_CYCLES - 1)) && !SPI_DONE;
  assign last_smp = (smp_cnt == SW'((1 << AVG_LOG2) - 1));

  assign SPI_START = (state == REQ);
  assign BUSY      = (state != IDLE);
  assign X_AVG     = avg[0];
  assign Y_AVG     = avg[1];
  assign Z_AVG     = avg[2];

  always_ff @(posedge CLK) begin
    if (RST || !EN || tick) per_cnt <= '0;
    else                    per_cnt <= per_cnt + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (tick) state_nxt = REQ;
      REQ:     state_nxt = WAIT;
      WAIT:    if (SPI_DONE) state_nxt = ACCUM;
               else if (to_hit) state_nxt = IDLE;
      ACCUM:   state_nxt = last_smp ? EMIT : IDLE;
      EMIT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      to_cnt    <= '0;
      smp_cnt   <= '0;
      AVG_VALID <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        cap[i] <= '0;
        acc[i] <= '0;
        avg[i] <= '0;
      end
    end else begin
      AVG_VALID <= (state == EMIT);
      case (state)
        REQ: to_cnt <= '0;
        WAIT: begin
          to_cnt <= to_cnt + 1'b1;
          if (SPI_DONE)
            for (int i = 0; i < 3; i++) cap[i] <= din[i];
        end
        ACCUM: begin
          for (int i = 0; i < 3; i++) acc[i] <= acc[i] + AW'(cap[i]);
          if (!last_smp) smp_cnt <= smp_cnt + 1'b1;
        end
        EMIT: begin
          // arithmetic shift floors toward -inf
          for (int i = 0; i < 3; i++) begin
            avg[i] <= 10'(acc[i] >>> AVG_LOG2);
            acc[i] <= '0;
          end
          smp_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  // set beats clear when both land in the same cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      ERR_TIMEOUT <= 1'b0;
      ERR_OVERRUN <= 1'b0;
    end else begin
      if (to_hit)       ERR_TIMEOUT <= 1'b1;
      else if (CLR_ERR) ERR_TIMEOUT <= 1'b0;
      if (tick && state != IDLE) ERR_OVERRUN <= 1'b1;
      else if (CLR_ERR)          ERR_OVERRUN <= 1'b0;
    end
  end
endmodule

// File: tb/tb_acl_sample_scheduler.sv
// Bench for acl_sample_scheduler: acts as the SPI wrapper with random data and
// delays, and checks averages against a sample-queue model.
module tb_acl_sample_scheduler;
  logic       CLK = 1'b0, RST = 1'b1, EN = 1'b0, CLR_ERR = 1'b0, SPI_DONE = 1'b0;
  logic [9:0] X_IN = '0, Y_IN = '0, Z_IN = '0;
  logic       SPI_START, AVG_VALID, BUSY, ERR_TIMEOUT, ERR_OVERRUN;
  logic [9:0] X_AVG, Y_AVG, Z_AVG;

  acl_sample_scheduler #(.SAMPLE_DIV(16), .TIMEOUT_CYCLES(20), .AVG_LOG2(2)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .CLR_ERR(CLR_ERR),
    .SPI_START(SPI_START), .SPI_DONE(SPI_DONE),
    .X_IN(X_IN), .Y_IN(Y_IN), .Z_IN(Z_IN),
    .X_AVG(X_AVG), .Y_AVG(Y_AVG), .Z_AVG(Z_AVG),
    .AVG_VALID(AVG_VALID), .BUSY(BUSY),
    .ERR_TIMEOUT(ERR_TIMEOUT), .ERR_OVERRUN(ERR_OVERRUN)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct { int c; logic [9:0] x, y, z; } ev_t;
  ev_t avq[$];
  int  starts[$];
  ev_t mon_e;

  always @(negedge CLK) begin
    if (!RST) begin
      if (SPI_START) starts.push_back(cyc);
      if (AVG_VALID) begin
        mon_e.c = cyc; mon_e.x = X_AVG; mon_e.y = Y_AVG; mon_e.z = Z_AVG;
        avq.push_back(mon_e);
      end
    end
  end

  int n_chk = 0, n_pass = 0;
  int last_start = 0;
  int pend_x[$], pend_y[$], pend_z[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int sx(input logic [9:0] v);
    return v[9] ? int'(v) - 1024 : int'(v);
  endfunction

  // floor(sum/4), wrapped to the 10-bit output field
  function automatic int favg(input int q[$]);
    int s, r;
    s = 0;
    foreach (q[i]) s += q[i];
    r = s / 4;
    if (s < 0 && (s % 4) != 0) r = r - 1;
    return r & 'h3FF;
  endfunction

  task automatic chk_reset_vals(input string p);
    chk({p, "_spi_start"}, SPI_START, 0);
    chk({p, "_avg_valid"}, AVG_VALID, 0);
    chk({p, "_busy"}, BUSY, 0);
    chk({p, "_err_to"}, ERR_TIMEOUT, 0);
    chk({p, "_err_ovr"}, ERR_OVERRUN, 0);
    chk({p, "_x_avg"}, X_AVG, 0);
    chk({p, "_y_avg"}, Y_AVG, 0);
    chk({p, "_z_avg"}, Z_AVG, 0);
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(negedge CLK);
      if (SPI_START) ok = 1'b1;
    end
    if (!ok) chk("start_seen", 0, 1);
    else last_start = cyc;
  endtask

  // one successful read: DONE d cycles after the START cycle
  task automatic do_read(input logic [9:0] x, y, z, input int d, input bit stray);
    bit ok;
    int dcyc, ex, ey, ez;
    ev_t e;
    if (stray) begin
      SPI_DONE = 1'b1; X_IN = 10'($urandom); Y_IN = 10'($urandom); Z_IN = 10'($urandom);
      @(posedge CLK); #1 SPI_DONE = 1'b0;
    end
    wait_start(ok);
    if (!ok) return;
    repeat (d) @(posedge CLK);
    #1;
    SPI_DONE = 1'b1; X_IN = x; Y_IN = y; Z_IN = z;
    dcyc = cyc;
    @(posedge CLK); #1 SPI_DONE = 1'b0;
    pend_x.push_back(sx(x)); pend_y.push_back(sx(y)); pend_z.push_back(sx(z));
    if (pend_x.size() == 4) begin
      ex = favg(pend_x); ey = favg(pend_y); ez = favg(pend_z);
      pend_x.delete(); pend_y.delete(); pend_z.delete();
      repeat (3) @(negedge CLK);
      #1;
      chk("avg_count", avq.size(), 1);
      if (avq.size() > 0) begin
        e = avq.pop_front();
        chk("avg_cycle", e.c, dcyc + 3);
        chk("x_avg", e.x, ex);
        chk("y_avg", e.y, ey);
        chk("z_avg", e.z, ez);
      end
      avq.delete();
    end
  endtask

  logic [9:0] xs[4] = '{10'd10, 10'd11, 10'd12, 10'd13};
  logic [9:0] ys[4] = '{10'h3FF, 10'h3FE, 10'h3FF, 10'h3FE};
  logic [9:0] zs[4] = '{10'h200, 10'h201, 10'h1FF, 10'h005};

  initial begin
    int en_cyc, bad, s, s_late, r;
    bit ok;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_reset_vals("rst");
    @(posedge CLK); #1 RST = 1'b0;
    repeat (40) @(posedge CLK);
    #1;
    chk("no_start_en0", starts.size(), 0);
    EN = 1'b1; en_cyc = cyc;

    for (int i = 0; i < 4; i++) begin
      do_read(xs[i], ys[i], zs[i], $urandom_range(1, 8), 1'b0);
      if (i == 2) begin
        @(negedge CLK);
        chk("pre_x_avg", X_AVG, 0); chk("pre_y_avg", Y_AVG, 0); chk("pre_z_avg", Z_AVG, 0);
      end
    end
    chk("x_dir", X_AVG, 11);
    chk("y_dir", Y_AVG, 'h3FE);

    for (int i = 0; i < 20; i++)
      do_read(10'($urandom), 10'($urandom), 10'($urandom), $urandom_range(1, 8),
              $urandom_range(0, 3) == 0);

    chk("start_count", starts.size(), 24);
    if (starts.size() > 0) chk("first_start", starts[0], en_cyc + 16);
    bad = 0;
    for (int i = 1; i < starts.size(); i++) if (starts[i] - starts[i-1] != 16) bad++;
    chk("period_bad", bad, 0);
    chk("to_clean", ERR_TIMEOUT, 0);
    chk("ovr_clean", ERR_OVERRUN, 0);

    // timeout with two samples already accumulated
    for (int i = 0; i < 2; i++)
      do_read(10'($urandom), 10'($urandom), 10'($urandom), $urandom_range(1, 8), 1'b0);
    wait_start(ok);
    repeat (20) @(negedge CLK);
    chk("to_early", ERR_TIMEOUT, 0);
    chk("busy_wait", BUSY, 1);
    chk("ovr_tick_in_wait", ERR_OVERRUN, 1);
    @(negedge CLK);
    chk("to_set", ERR_TIMEOUT, 1);
    chk("idle_after_to", BUSY, 0);
    for (int i = 0; i < 2; i++)
      do_read(10'($urandom), 10'($urandom), 10'($urandom), $urandom_range(1, 8), 1'b0);
    @(posedge CLK); #1 CLR_ERR = 1'b1;
    @(posedge CLK); #1 CLR_ERR = 1'b0;
    @(negedge CLK);
    chk("clr_to", ERR_TIMEOUT, 0);
    chk("clr_ovr", ERR_OVERRUN, 0);

    // clear coincident with a new timeout: timeout stays, overrun clears
    wait_start(ok);
    repeat (20) @(posedge CLK);
    #1 CLR_ERR = 1'b1;
    @(posedge CLK); #1 CLR_ERR = 1'b0;
    @(negedge CLK);
    chk("to_set_wins", ERR_TIMEOUT, 1);
    chk("ovr_cleared", ERR_OVERRUN, 0);
    @(posedge CLK); #1 CLR_ERR = 1'b1;
    @(posedge CLK); #1 CLR_ERR = 1'b0;

    // DONE exactly at the timeout limit, after a tick in WAIT
    s = last_start;
    do_read(10'($urandom), 10'($urandom), 10'($urandom), 20, 1'b0);
    s_late = last_start;
    chk("late_start_gap", s_late - s, 32);
    chk("done_wins_to", ERR_TIMEOUT, 0);
    chk("late_ovr", ERR_OVERRUN, 1);
    do_read(10'($urandom), 10'($urandom), 10'($urandom), $urandom_range(1, 8), 1'b0);
    chk("no_early_restart", last_start - s_late, 32);

    // reset in WAIT with 2 of 4 samples pending
    wait_start(ok);
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk_reset_vals("midrst");
    @(posedge CLK); #1 RST = 1'b0;
    r = cyc;
    pend_x.delete(); pend_y.delete(); pend_z.delete();
    avq.delete();
    @(negedge CLK);
    chk("no_start_after_rst", SPI_START, 0);
    for (int i = 0; i < 4; i++) begin
      do_read(10'($urandom), 10'($urandom), 10'($urandom), $urandom_range(1, 8), 1'b0);
      if (i == 0) chk("rst_first_start", last_start, r + 16);
    end
    chk("stray_avg", avq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end
endmodule
